// File: rtl/aer_pkg.sv
// Shared access-size encodings and response payload for the SRAM byte
// read controller.
package aer_pkg;

    // Widest SRAM word supported; payload data is sized to it.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        SIZE_BT = 2'd0,
        SIZE_HW = 2'd1,
        SIZE_WD = 2'd2,
        SIZE_DW = 2'd3
    } size_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic                 err;
    } rd_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous DEPTH x rd_rsp_t response FIFO.
// Ports: push/push_data_i in, pop/pop_data_o out, full_o, empty_o, cnt_o.
module sram_rsp_fifo
    import aer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  rd_rsp_t       push_data_i,
    input  logic          pop_i,
    output rd_rsp_t       pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] cnt_o
);

    rd_rsp_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (cnt_o == CW'(DEPTH));
    assign empty_o    = (cnt_o == '0);
    assign do_pop     = pop_i & ~empty_o;
    // A push into a full buffer is legal when a pop frees a slot this cycle.
    assign do_push    = push_i & (~full_o | do_pop);
    assign pop_data_o = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_o  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   cnt_o <= cnt_o + 1'b1;
                2'b01:   cnt_o <= cnt_o - 1'b1;
                default: cnt_o <= cnt_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/sram_byte_rd_ctrl.sv
// Byte-addressed read controller over a 1-cycle SRAM: issues word reads,
// extracts/extends the addressed lane(s), returns in-order buffered responses.
// Ports: req_* (valid/ready request), sram_* (read port), rsp_* (valid/ready response).
module sram_byte_rd_ctrl
    import aer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int RSP_DEPTH = 2,
    localparam int AWIDTH  = $clog2(DEPTH * WIDTH / 8),
    localparam int BIT_END = $clog2(WIDTH / 8),
    localparam int SAW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    output logic              sram_en_o,
    output logic [SAW-1:0]    sram_addr_o,
    input  logic [WIDTH-1:0]  sram_rdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_err_o
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    size_t              req_size;
    logic               req_err;
    logic               accept;
    logic               pop;
    logic               s1_valid;
    logic [BIT_END-1:0] s1_lane;
    size_t              s1_size;
    logic               s1_signed;
    logic               s1_err;
    rd_rsp_t            push_data;
    rd_rsp_t            head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_cnt;
    logic               unused_bits;

    function automatic logic chk_err(input logic [AWIDTH-1:0] addr,
                                     input size_t sz);
        logic [2:0] lo;
        logic       misalign;
        logic       oversize;
        lo       = 3'(addr);
        // For dword the 3-bit shift wraps to 0, so the mask becomes 3'b111.
        misalign = |(lo & ((3'd1 << sz) - 3'd1));
        oversize = (32'd1 << sz) > 32'(WIDTH / 8);
        return misalign | oversize;
    endfunction

    function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] rd,
                                                 input logic [BIT_END-1:0] lane,
                                                 input size_t sz,
                                                 input logic sgn);
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] res;
        int               nb;
        logic             sb;
        sh  = rd >> {lane, 3'b000};
        nb  = 8 << sz;
        sb  = 1'b0;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == nb - 1) sb = sh[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = (i < nb) ? sh[i] : (sgn & sb);
        end
        return res;
    endfunction

    assign req_size = size_t'(req_size_i);
    assign req_err  = chk_err(req_addr_i, req_size);
    assign pop      = rsp_valid_o & rsp_ready_i;

    // Occupancy seen by the next accept: buffered + in S1 - leaving now.
    assign req_ready_o = (int'(fifo_cnt) + int'(s1_valid) - int'(pop))
                         < RSP_DEPTH;
    assign accept      = req_valid_i & req_ready_o;
    assign sram_en_o   = accept & ~req_err;
    assign sram_addr_o = req_addr_i[AWIDTH-1:BIT_END];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_lane   <= '0;
            s1_size   <= SIZE_BT;
            s1_signed <= 1'b0;
            s1_err    <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_lane   <= req_addr_i[BIT_END-1:0];
                s1_size   <= req_size;
                s1_signed <= req_signed_i;
                s1_err    <= req_err;
            end
        end
    end

    always_comb begin
        push_data      = '0;
        push_data.err  = s1_err;
        if (!s1_err) begin
            push_data.data = MAX_WIDTH'(extract(sram_rdata_i, s1_lane,
                                                s1_size, s1_signed));
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (s1_valid),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .cnt_o       (fifo_cnt)
    );

    // Payload RAM is not reset, so gate the outputs while empty.
    assign rsp_valid_o = ~fifo_empty;
    assign rsp_data_o  = fifo_empty ? '0 : head.data[WIDTH-1:0];
    assign rsp_err_o   = ~fifo_empty & head.err;

    assign unused_bits = ^head.data ^ fifo_full;

endmodule

// File: tb/tb_sram_byte_rd_ctrl.sv
// Directed scoreboard bench for sram_byte_rd_ctrl (WIDTH=32, DEPTH=16).
// Bench-side SRAM model with word 1 = 0xA1B2C3D4, word 2 = 0x11223344.
module tb_sram_byte_rd_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic        sram_en_o;
    logic [3:0]  sram_addr_o;
    logic [31:0] sram_rdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int st;
    int tot;

    logic [31:0] mem [16];
    logic [32:0] exp_q [$];
    int          pop_cyc [$];

    sram_byte_rd_ctrl #(
        .WIDTH     (32),
        .DEPTH     (16),
        .RSP_DEPTH (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .sram_en_o    (sram_en_o),
        .sram_addr_o  (sram_addr_o),
        .sram_rdata_i (sram_rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (sram_en_o) sram_rdata_i <= mem[sram_addr_o];
    end

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", name, obs, expv);
        end
    endtask

    // Scoreboard consumer: compare each response as it is handed off.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data_o), 64'(e[31:0]));
                chk("rsp_err", 64'(rsp_err_o), 64'(e[32]));
            end
        end
    end

    // Drives a request, waits (bounded) for acceptance, returns after the edge.
    task automatic send(input logic [5:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] ed,
                        input logic ee, output int stalls);
        req_valid_i  = 1'b1;
        req_addr_i   = a;
        req_size_i   = sz;
        req_signed_i = sg;
        stalls       = 0;
        @(negedge clk_i);
        while (!req_ready_o && stalls < 50) begin
            stalls++;
            @(negedge clk_i);
        end
        if (!req_ready_o) begin
            chk("accept_timeout", 64'(req_ready_o), 64'd1);
        end else begin
            chk("sram_en", 64'(sram_en_o), 64'(!ee));
            exp_q.push_back({ee, ed});
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid_o) && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'hA1B2C3D4;
        mem[2] = 32'h11223344;
        sram_rdata_i = '0;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_size_i   = '0;
        req_signed_i = 1'b0;
        rsp_ready_i  = 1'b1;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_sram_en", 64'(sram_en_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Byte 0x6 signed, with latency and word-address checks.
        send(6'h6, 2'd0, 1'b1, 32'hFFFFFFB2, 1'b0, st);
        chk("sram_addr", 64'(sram_addr_o), 64'd1);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lat_s1", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        chk("lat_rsp", 64'(rsp_valid_o), 64'd1);
        @(posedge clk_i);
        #1;

        send(6'h6, 2'd0, 1'b0, 32'h000000B2, 1'b0, st);
        send(6'h6, 2'd1, 1'b1, 32'hFFFFA1B2, 1'b0, st);
        send(6'h4, 2'd1, 1'b0, 32'h0000C3D4, 1'b0, st);
        send(6'h4, 2'd2, 1'b1, 32'hA1B2C3D4, 1'b0, st);
        send(6'h5, 2'd1, 1'b0, 32'h00000000, 1'b1, st);
        send(6'h0, 2'd3, 1'b1, 32'h00000000, 1'b1, st);
        send(6'h2, 2'd2, 1'b0, 32'h00000000, 1'b1, st);
        req_valid_i = 1'b0;
        drain();

        // Back-to-back with a ready consumer.
        pop_cyc.delete();
        tot = 0;
        send(6'h8, 2'd0, 1'b0, 32'h00000044, 1'b0, st);
        tot += st;
        send(6'h9, 2'd0, 1'b0, 32'h00000033, 1'b0, st);
        tot += st;
        send(6'hA, 2'd0, 1'b1, 32'h00000022, 1'b0, st);
        tot += st;
        send(6'hB, 2'd0, 1'b0, 32'h00000011, 1'b0, st);
        tot += st;
        req_valid_i = 1'b0;
        drain();
        chk("b2b_stalls", 64'(tot), 64'd0);
        chk("b2b_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4)
            chk("b2b_consec", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // Backpressure: two accepted, third held off.
        rsp_ready_i = 1'b0;
        send(6'h4, 2'd2, 1'b0, 32'hA1B2C3D4, 1'b0, st);
        send(6'h7, 2'd0, 1'b0, 32'h000000A1, 1'b0, st);
        req_addr_i   = 6'h4;
        req_size_i   = 2'd1;
        req_signed_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("bp_ready", 64'(req_ready_o), 64'd0);
            chk("bp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_hold", 64'(rsp_data_o), 64'hA1B2C3D4);
        end
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        send(6'h4, 2'd1, 1'b1, 32'hFFFFC3D4, 1'b0, st);
        chk("bp_release", 64'(st), 64'd0);
        req_valid_i = 1'b0;
        drain();

        // Reset with responses buffered and one in flight.
        rsp_ready_i = 1'b0;
        send(6'h4, 2'd2, 1'b0, 32'hA1B2C3D4, 1'b0, st);
        send(6'h6, 2'd1, 1'b0, 32'h0000A1B2, 1'b0, st);
        req_valid_i = 1'b0;
        chk("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_valid", 64'(rsp_valid_o), 64'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_valid", 64'(rsp_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        send(6'h6, 2'd0, 1'b1, 32'hFFFFFFB2, 1'b0, st);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("post_lat_s1", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        chk("post_lat_rsp", 64'(rsp_valid_o), 64'd1);
        @(posedge clk_i);
        #1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
